// File: rtl/divider_scheduler_pkg.sv
// Shared constants, reset defaults and config-FSM types for the divider scheduler.
// Also holds the config-request validity rule used by the top.
package divider_scheduler_pkg;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 8;

    // Index 0 is the least significant slice: ch0 = 4/2, ch1 = 10/5, ch2 = 20/10.
    localparam logic [NUM_CH-1:0][CNT_W-1:0] DEF_PERIOD = {8'd20, 8'd10, 8'd4};
    localparam logic [NUM_CH-1:0][CNT_W-1:0] DEF_HIGH   = {8'd10, 8'd5,  8'd2};

    typedef enum logic [0:0] {
        S_IDLE,
        S_WAIT
    } cfg_state_e;

    function automatic logic cfg_is_valid(
        input logic [1:0]       ch,
        input logic [CNT_W-1:0] period,
        input logic [CNT_W-1:0] high
    );
        return (32'(ch) < NUM_CH) && (period >= CNT_W'(2)) &&
               (high != '0) && (high < period);
    endfunction

endpackage

// File: rtl/divider_channel.sv
// One divided-clock channel: period counter, registered clk_out and tick.
// A load is taken only on a boundary so the running period is never cut short.
module divider_channel
    import divider_scheduler_pkg::*;
#(
    parameter logic [CNT_W-1:0] DefPeriod = 8'd4,
    parameter logic [CNT_W-1:0] DefHigh   = 8'd2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] new_period,
    input  logic [CNT_W-1:0] new_high,
    output logic             clk_out,
    output logic             tick,
    output logic             boundary
);

    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             apply;

    always_comb begin
        wrap     = (cnt_q == (period_q - CNT_W'(1)));
        boundary = !en || wrap;
        apply    = load && boundary;

        period_d = period_q;
        high_d   = high_q;
        if (apply) begin
            period_d = new_period;
            high_d   = new_high;
        end

        // A disabled channel parks at P-1 so re-enabling starts a fresh period.
        if (!en) begin
            cnt_d = period_d - CNT_W'(1);
        end else if (apply || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        clk_out_d = en && (cnt_d < high_d);
        tick_d    = en && (cnt_d == '0);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            period_q  <= DefPeriod;
            high_q    <= DefHigh;
            cnt_q     <= DefPeriod - CNT_W'(1);
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            period_q  <= period_d;
            high_q    <= high_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/divider_scheduler.sv
// Runtime-programmable multi-channel clock divider with a single-entry config
// scheduler that applies a new ratio on the target channel's period boundary.
module divider_scheduler
    import divider_scheduler_pkg::*;
(
    input  logic              clock_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    output logic              cfg_done,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    cfg_state_e       state_q, state_d;
    logic [1:0]       shadow_ch_q, shadow_ch_d;
    logic [CNT_W-1:0] shadow_period_q, shadow_period_d;
    logic [CNT_W-1:0] shadow_high_q, shadow_high_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_done_q, cfg_done_d;

    logic [NUM_CH-1:0] boundary;
    logic [NUM_CH-1:0] load;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        divider_channel #(
            .DefPeriod(DEF_PERIOD[i]),
            .DefHigh  (DEF_HIGH[i])
        ) u_channel (
            .clock_in  (clock_in),
            .reset     (reset),
            .en        (ch_en[i]),
            .load      (load[i]),
            .new_period(shadow_period_q),
            .new_high  (shadow_high_q),
            .clk_out   (clk_out[i]),
            .tick      (tick[i]),
            .boundary  (boundary[i])
        );
    end

    // Only the pending target sees a load, and only once it reaches a boundary.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ((state_q == S_WAIT) && (32'(shadow_ch_q) == i)) begin
                load[i] = boundary[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        shadow_ch_d     = shadow_ch_q;
        shadow_period_d = shadow_period_q;
        shadow_high_d   = shadow_high_q;
        cfg_err_d       = 1'b0;
        cfg_done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_is_valid(cfg_ch, cfg_period, cfg_high)) begin
                        shadow_ch_d     = cfg_ch;
                        shadow_period_d = cfg_period;
                        shadow_high_d   = cfg_high;
                        state_d         = S_WAIT;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (|load) begin
                    cfg_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            shadow_ch_q     <= '0;
            shadow_period_q <= '0;
            shadow_high_q   <= '0;
            cfg_err_q       <= 1'b0;
            cfg_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            shadow_ch_q     <= shadow_ch_d;
            shadow_period_q <= shadow_period_d;
            shadow_high_q   <= shadow_high_d;
            cfg_err_q       <= cfg_err_d;
            cfg_done_q      <= cfg_done_d;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign cfg_err   = cfg_err_q;
    assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_divider_scheduler.sv
// Self-checking bench for divider_scheduler: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model of the divider.
module tb_divider_scheduler;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] ch_en = 3'b000;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_period = 8'd0;
    logic [7:0] cfg_high = 8'd0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       cfg_done;
    logic [2:0] clk_out;
    logic [2:0] tick;

    divider_scheduler dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
        .cfg_done  (cfg_done),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clock_in = ~clock_in;

    int total = 0;
    int bad = 0;

    // Behavioural model: phase of each channel within its period.
    int         DP[3] = '{4, 10, 20};
    int         DH[3] = '{2, 5, 10};
    int         m_p[3];
    int         m_h[3];
    int         m_cnt[3];
    logic [2:0] e_clk;
    logic [2:0] e_tick;
    logic       e_err;
    logic       e_done;
    bit         pend;
    int         pch, pp, ph;

    wire [8:0] obs_vec = {cfg_ready, cfg_err, cfg_done, clk_out, tick};

    function automatic logic [8:0] exp_vec();
        return {!pend, e_err, e_done, e_clk, e_tick};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_p[c]   = DP[c];
            m_h[c]   = DH[c];
            m_cnt[c] = DP[c] - 1;
        end
        e_clk  = '0;
        e_tick = '0;
        e_err  = 1'b0;
        e_done = 1'b0;
        pend   = 1'b0;
    endtask

    task automatic model_step();
        bit ld[3];
        bit any_ld;
        any_ld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ld[c] = pend && (pch == c) && (!ch_en[c] || (m_cnt[c] == m_p[c] - 1));
            any_ld |= ld[c];
        end
        e_err  = 1'b0;
        e_done = 1'b0;
        if (!pend) begin
            if (cfg_valid) begin
                if (int'(cfg_ch) >= 3 || int'(cfg_period) < 2 || cfg_high == 8'd0 ||
                    cfg_high >= cfg_period) begin
                    e_err = 1'b1;
                end else begin
                    pend = 1'b1;
                    pch  = int'(cfg_ch);
                    pp   = int'(cfg_period);
                    ph   = int'(cfg_high);
                end
            end
        end else if (any_ld) begin
            pend   = 1'b0;
            e_done = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            if (ld[c]) begin
                m_p[c] = pp;
                m_h[c] = ph;
            end
            if (!ch_en[c]) begin
                m_cnt[c]  = m_p[c] - 1;
                e_clk[c]  = 1'b0;
                e_tick[c] = 1'b0;
            end else begin
                m_cnt[c]  = ld[c] ? 0 : (m_cnt[c] + 1) % m_p[c];
                e_clk[c]  = (m_cnt[c] < m_h[c]);
                e_tick[c] = (m_cnt[c] == 0);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock_in);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int nt[3];
        int nh[3];
        nt = '{0, 0, 0};
        nh = '{0, 0, 0};
        reset = 1'b1;
        ch_en = 3'b000;
        cfg_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clock_in);
        #1;
        total++;
        if (obs_vec !== 9'b100000000) begin
            bad++;
            $display("FAIL reset_state: got %b want %b", obs_vec, 9'b100000000);
        end
        reset = 1'b0;
        ch_en = 3'b111;
        for (int i = 0; i < 40; i++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL default_run cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
            if (i == 0) begin
                total++;
                if (tick !== 3'b111 || clk_out !== 3'b111) begin
                    bad++;
                    $display("FAIL first_edge: tick=%b clk=%b want 111/111", tick, clk_out);
                end
            end
            for (int c = 0; c < 3; c++) begin
                nt[c] += int'(tick[c]);
                nh[c] += int'(clk_out[c]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (nt[c] != 40 / DP[c] || nh[c] != 20) begin
                bad++;
                $display("FAIL default_ratio ch%0d: ticks=%0d high=%0d want %0d/20",
                         c, nt[c], nh[c], 40 / DP[c]);
            end
        end
    endtask

    task automatic test_cfg_mid_period();
        int  n;
        int  nh;
        bit  found;
        n = 0;
        while (m_cnt[1] != 3 && n < 20) begin
            cyc();
            n++;
        end
        cfg_valid = 1'b1;
        cfg_ch = 2'd1;
        cfg_period = 8'd6;
        cfg_high = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        total++;
        if (obs_vec !== exp_vec() || cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_accept: got %b want %b (ready 0)", obs_vec, exp_vec());
        end
        found = 1'b0;
        for (n = 1; n <= 20; n++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL mid_wait cyc %0d: got %b want %b", n, obs_vec, exp_vec());
            end
            if (cfg_done) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || n != 6) begin
            bad++;
            $display("FAIL mid_latency: got %0d edges (found=%0d) want 6", n, found);
        end
        total++;
        if (tick[1] !== 1'b1 || clk_out[1] !== 1'b1 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_apply: tick=%b clk=%b ready=%b want 1/1/1",
                     tick[1], clk_out[1], cfg_ready);
        end
        nh = int'(clk_out[1]);
        for (int i = 0; i < 11; i++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL mid_new cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
            nh += int'(clk_out[1]);
        end
        total++;
        if (nh != 6) begin
            bad++;
            $display("FAIL mid_duty: high=%0d want 6", nh);
        end
    endtask

    task automatic test_invalid();
        int chs[4] = '{1, 1, 1, 3};
        int per[4] = '{6, 5, 1, 6};
        int hig[4] = '{0, 5, 1, 3};
        for (int k = 0; k < 4; k++) begin
            cfg_valid = 1'b1;
            cfg_ch = 2'(chs[k]);
            cfg_period = 8'(per[k]);
            cfg_high = 8'(hig[k]);
            cyc();
            cfg_valid = 1'b0;
            total++;
            if (obs_vec !== exp_vec() || cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
                bad++;
                $display("FAIL invalid_%0d: got %b want %b (err 1 ready 1)",
                         k, obs_vec, exp_vec());
            end
            cyc();
            total++;
            if (obs_vec !== exp_vec() || cfg_err !== 1'b0) begin
                bad++;
                $display("FAIL invalid_pulse_%0d: got %b want %b", k, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_wrap_edge();
        int  n;
        bit  found;
        n = 0;
        while (m_cnt[2] != 19 && n < 25) begin
            cyc();
            n++;
        end
        cfg_valid = 1'b1;
        cfg_ch = 2'd2;
        cfg_period = 8'd8;
        cfg_high = 8'd4;
        cyc();
        cfg_valid = 1'b0;
        found = 1'b0;
        for (n = 1; n <= 40; n++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_wait cyc %0d: got %b want %b", n, obs_vec, exp_vec());
            end
            if (cfg_done) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || n != 20) begin
            bad++;
            $display("FAIL wrap_latency: got %0d edges (found=%0d) want 20", n, found);
        end
    endtask

    task automatic test_disable();
        int nt;
        int n;
        ch_en = 3'b110;
        for (int i = 0; i < 7; i++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec() || clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
                bad++;
                $display("FAIL disabled cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
        end
        ch_en = 3'b111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec() || clk_out[0] !== (i < 2) || tick[0] !== (i == 0)) begin
                bad++;
                $display("FAIL restart cyc %0d: clk=%b tick=%b want %0d/%0d",
                         i, clk_out[0], tick[0], i < 2, i == 0);
            end
        end
        ch_en = 3'b110;
        cyc();
        cfg_valid = 1'b1;
        cfg_ch = 2'd0;
        cfg_period = 8'd5;
        cfg_high = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        cyc();
        total++;
        if (obs_vec !== exp_vec() || cfg_done !== 1'b1 || clk_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL disabled_apply: got %b want %b (done 1)", obs_vec, exp_vec());
        end
        ch_en = 3'b111;
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL new_ch0 cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
            nt += int'(tick[0]);
        end
        total++;
        if (nt != 2) begin
            bad++;
            $display("FAIL new_ch0_ticks: got %0d want 2", nt);
        end
        // Drop the target's enable while its config is pending.
        n = 0;
        while (m_cnt[2] != 0 && n < 20) begin
            cyc();
            n++;
        end
        cfg_valid = 1'b1;
        cfg_ch = 2'd2;
        cfg_period = 8'd6;
        cfg_high = 8'd2;
        cyc();
        cfg_valid = 1'b0;
        ch_en = 3'b011;
        cyc();
        total++;
        if (obs_vec !== exp_vec() || cfg_done !== 1'b1) begin
            bad++;
            $display("FAIL drop_in_wait: got %b want %b (done 1)", obs_vec, exp_vec());
        end
        ch_en = 3'b111;
        cyc();
    endtask

    task automatic test_reset_in_wait();
        int nd;
        int nt;
        cfg_valid = 1'b1;
        cfg_ch = 2'd2;
        cfg_period = 8'd50;
        cfg_high = 8'd25;
        cyc();
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec() || cfg_ready !== 1'b0) begin
                bad++;
                $display("FAIL pre_reset cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs_vec !== 9'b100000000) begin
            bad++;
            $display("FAIL reset_mid_wait: got %b want %b", obs_vec, 9'b100000000);
        end
        repeat (2) @(posedge clock_in);
        #1;
        reset = 1'b0;
        nd = 0;
        nt = 0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL post_reset cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
            nd += int'(cfg_done);
            nt += int'(tick[2]);
        end
        total++;
        if (nd != 0 || nt != 2) begin
            bad++;
            $display("FAIL reset_discard: done=%0d ch2_ticks=%0d want 0/2", nd, nt);
        end
    endtask

    task automatic test_random();
        int nd;
        nd = 0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 3; c++) begin
                ch_en[c] = ($urandom_range(0, 7) != 0);
            end
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_period = 8'($urandom_range(0, 12));
            cfg_high = 8'($urandom_range(0, 12));
            cyc();
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
            nd += int'(cfg_done);
        end
        cfg_valid = 1'b0;
        ch_en = 3'b111;
        total++;
        if (nd == 0) begin
            bad++;
            $display("FAIL random_activity: done count %0d want > 0", nd);
        end
    endtask

    initial begin
        test_reset();
        test_cfg_mid_period();
        test_invalid();
        test_wrap_edge();
        test_disable();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
